// File: rtl/toy_sram_arb.sv
// toy_sram_arb: shares the toy SRAM macro between the Wishbone slave
// port and the logic-analyzer port, one access per transaction.
module toy_sram_arb #(
    parameter int          AW   = 8,
    parameter int          DW   = 32,
    parameter logic [31:0] BASE = 32'h3000_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [DW-1:0] wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [DW-1:0] wbs_dat_o,
    input  logic          la_req,
    input  logic          la_we,
    input  logic [AW-1:0] la_addr,
    input  logic [DW-1:0] la_wdata,
    output logic          la_ack,
    output logic [DW-1:0] la_rdata,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    output logic [3:0]    sram_be,
    input  logic [DW-1:0] sram_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_ACK
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // r_last_la doubles as the owner of the transaction in flight
    logic          r_last_la;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_be;
    logic [DW-1:0] r_wb_rdata;
    logic [DW-1:0] r_la_rdata;

    logic w_wb_req;
    logic w_any_req;
    logic w_pick_la;
    logic w_grant;
    logic w_unused;

    assign w_wb_req  = wbs_cyc_i & wbs_stb_i
                     & (wbs_adr_i[31:AW+2] == BASE[31:AW+2]);
    assign w_any_req = w_wb_req | la_req;
    assign w_pick_la = la_req & (~w_wb_req | ~r_last_la);
    assign w_grant   = (r_state == S_IDLE) & w_any_req;
    assign w_unused  = &{1'b0, wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = r_we ? S_ACK : S_CAPT;
            end
            S_CAPT: begin
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_last_la <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
        end else if (w_grant) begin
            r_last_la <= w_pick_la;
            if (w_pick_la) begin
                r_we    <= la_we;
                r_addr  <= la_addr;
                r_wdata <= la_wdata;
                r_be    <= 4'hF;
            end else begin
                r_we    <= wbs_we_i;
                r_addr  <= wbs_adr_i[AW+1:2];
                r_wdata <= wbs_dat_i;
                r_be    <= wbs_sel_i;
            end
        end
    end

    // macro read data is valid during CAPT; only the owner's register loads
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wb_rdata <= '0;
            r_la_rdata <= '0;
        end else if (r_state == S_CAPT) begin
            if (r_last_la) begin
                r_la_rdata <= sram_rdata;
            end else begin
                r_wb_rdata <= sram_rdata;
            end
        end
    end

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_be    = '0;
        wbs_ack_o  = 1'b0;
        la_ack     = 1'b0;
        busy       = (r_state != S_IDLE);
        unique case (r_state)
            S_ISSUE: begin
                sram_ce    = 1'b1;
                sram_we    = r_we;
                sram_addr  = r_addr;
                sram_wdata = r_wdata;
                sram_be    = r_be;
            end
            S_ACK: begin
                wbs_ack_o = ~r_last_la;
                la_ack    = r_last_la;
            end
            default: begin
            end
        endcase
    end

    assign wbs_dat_o = r_wb_rdata;
    assign la_rdata  = r_la_rdata;

endmodule

// File: tb/tb_toy_sram_arb.sv
// tb_toy_sram_arb: directed vector table, hand sequences and random
// two-port traffic scored against a transaction-level reference model.
module tb_toy_sram_arb;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        la_req, la_we;
    logic [7:0]  la_addr;
    logic [31:0] la_wdata;
    logic        la_ack;
    logic [31:0] la_rdata;
    logic        sram_ce, sram_we;
    logic [7:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_be;
    logic [31:0] sram_rdata;
    logic        busy;

    always #5 clk = ~clk;

    toy_sram_arb dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .la_req    (la_req),
        .la_we     (la_we),
        .la_addr   (la_addr),
        .la_wdata  (la_wdata),
        .la_ack    (la_ack),
        .la_rdata  (la_rdata),
        .sram_ce   (sram_ce),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_be   (sram_be),
        .sram_rdata(sram_rdata),
        .busy      (busy)
    );

    function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] nw,
                                        logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) old[8*b +: 8] = nw[8*b +: 8];
        return old;
    endfunction

    // SRAM macro model: registered read, byte-enabled write
    bit [31:0] mem [256];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_be);
            else         sram_rdata <= mem[sram_addr];
        end
    end

    int ce_viol = 0;
    int zero_viol = 0;
    bit prev_ce = 1'b0;
    always @(negedge clk) begin
        if (sram_ce && prev_ce) ce_viol <= ce_viol + 1;
        if (!sram_ce && (sram_we || sram_addr != 0 || sram_wdata != 0 || sram_be != 0))
            zero_viol <= zero_viol + 1;
        prev_ce <= sram_ce;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic drive_idle();
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        wbs_adr_i = 0; wbs_dat_i = 0;
        la_req = 0; la_we = 0; la_addr = 0; la_wdata = 0;
    endtask

    task automatic drive_wb(input bit we, input logic [7:0] wa,
                            input logic [31:0] wd, input logic [3:0] sel);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_sel_i = sel;
        wbs_adr_i = BASE | {22'd0, wa, 2'b00}; wbs_dat_i = wd;
    endtask

    task automatic drive_la(input bit we, input logic [7:0] wa, input logic [31:0] wd);
        la_req = 1; la_we = we; la_addr = wa; la_wdata = wd;
    endtask

    task automatic reset_dut();
        rst_n = 0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    int          lat, ce_k;
    logic [31:0] rd;
    logic [3:0]  bes;
    logic [7:0]  ads;
    logic        cwe, wrong;

    // one transaction from an idle DUT; called just after a rising edge
    task automatic do_txn(input bit is_la, input bit we, input logic [7:0] wa,
                          input logic [31:0] wd, input logic [3:0] sel);
        if (is_la) drive_la(we, wa, wd);
        else       drive_wb(we, wa, wd, sel);
        lat = -1; ce_k = -1; wrong = 0; rd = 0; bes = 0; ads = 0; cwe = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sram_ce) begin
                ce_k = k; bes = sram_be; ads = sram_addr; cwe = sram_we;
            end
            if (is_la ? wbs_ack_o : la_ack) wrong = 1;
            if (is_la ? la_ack : wbs_ack_o) begin
                lat = k;
                rd = is_la ? la_rdata : wbs_dat_o;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    typedef struct {
        bit          is_la;
        bit          we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t tbl [12];

    bit          act [2];
    int          gap [2], waitc [2], oth [2];
    bit          rwe [2];
    logic [7:0]  radr [2];
    logic [31:0] rwd [2];
    logic [3:0]  rbe [2];
    logic [31:0] exp_rd [2];
    bit [31:0]   ref_mem [256];

    initial begin
        int order [4];
        int n, wb_off, la_off, bad, cyc, ce_cyc, remaining;
        logic [31:0] la_before;
        logic [7:0]  acc_addr;
        logic [3:0]  acc_be;
        logic [31:0] acc_wd;
        bit          acc_we, bail, ackp;

        tbl[0]  = '{0, 1, 8'h10, 32'hA5A5A5A5, 4'hF, 32'h0, 2};
        tbl[1]  = '{0, 0, 8'h10, 32'h0, 4'hF, 32'hA5A5A5A5, 3};
        tbl[2]  = '{0, 1, 8'h10, 32'h11223344, 4'b0101, 32'h0, 2};
        tbl[3]  = '{0, 0, 8'h10, 32'h0, 4'hF, 32'hA522A544, 3};
        tbl[4]  = '{1, 0, 8'h10, 32'h0, 4'hF, 32'hA522A544, 3};
        tbl[5]  = '{1, 1, 8'h20, 32'hCAFEF00D, 4'hF, 32'h0, 2};
        tbl[6]  = '{0, 0, 8'h20, 32'h0, 4'hF, 32'hCAFEF00D, 3};
        tbl[7]  = '{0, 1, 8'h20, 32'hFFFFFFFF, 4'b1000, 32'h0, 2};
        tbl[8]  = '{1, 0, 8'h20, 32'h0, 4'hF, 32'hFFFEF00D, 3};
        tbl[9]  = '{0, 0, 8'h00, 32'h0, 4'hF, 32'h0, 3};
        tbl[10] = '{0, 1, 8'hFF, 32'h0BADC0DE, 4'hF, 32'h0, 2};
        tbl[11] = '{1, 0, 8'hFF, 32'h0, 4'hF, 32'h0BADC0DE, 3};

        // reset state
        rst_n = 0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {wbs_ack_o, la_ack, sram_ce, sram_we, busy, sram_be}, 0);
        chk("reset_addr_wdata", {sram_addr, 24'd0} | sram_wdata, 0);
        chk("reset_wb_rdata", wbs_dat_o, 0);
        chk("reset_la_rdata", la_rdata, 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        do_txn(0, 1, 8'h04, 32'hDEADBEEF, 4'hF);
        chk("wbw_ce_cycle", ce_k, 1);
        chk("wbw_addr", ads, 4);
        chk("wbw_we", cwe, 1);
        chk("wbw_lat", lat, 2);
        chk("wbw_wrong_ack", wrong, 0);

        do_txn(0, 0, 8'h04, 32'h0, 4'hF);
        chk("wbr_lat", lat, 3);
        chk("wbr_data", rd, 32'hDEADBEEF);

        do_txn(0, 1, 8'h04, 32'hDEADBEEF, 4'b0011);
        chk("wbw_sel_be", bes, 4'b0011);
        chk("wbw_sel_lat", lat, 2);

        // decode miss
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0400;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (sram_ce || wbs_ack_o || la_ack || busy) bad++;
        end
        chk("miss_quiet", bad, 0);
        @(posedge clk); #1;
        drive_idle();

        do_txn(1, 1, 8'hFF, 32'h12345678, 4'hF);
        chk("law_lat", lat, 2);
        chk("law_be", bes, 4'hF);
        chk("law_wrong_ack", wrong, 0);
        do_txn(1, 0, 8'hFF, 32'h0, 4'hF);
        chk("lar_lat", lat, 3);
        chk("lar_data", rd, 32'h12345678);

        // contention from reset: WB, LA, WB, LA
        reset_dut();
        drive_wb(0, 8'h04, 0, 4'hF);
        drive_la(0, 8'hFF, 0);
        n = 0; wb_off = 0; la_off = 0; la_before = 0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            @(negedge clk);
            if (wbs_ack_o && la_ack) chk("cont_both_ack", 1, 0);
            if (wbs_ack_o && n < 4) begin
                order[n] = 0; n++;
                chk("cont_wb_data", wbs_dat_o, 32'hDEADBEEF);
                chk("cont_la_hold", la_rdata, la_before);
                wb_off = 2;
            end
            if (la_ack && n < 4) begin
                order[n] = 1; n++;
                chk("cont_la_data", la_rdata, 32'h12345678);
                la_before = la_rdata;
                la_off = 2;
            end
            @(posedge clk); #1;
            if (wb_off > 0) begin
                wb_off--;
                wbs_cyc_i = (wb_off == 0); wbs_stb_i = (wb_off == 0);
            end
            if (la_off > 0) begin
                la_off--;
                la_req = (la_off == 0);
            end
        end
        chk("cont_count", n, 4);
        chk("cont_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
        drive_idle();
        repeat (8) @(posedge clk);
        #1;

        // reset during ISSUE of a read
        drive_wb(0, 8'h04, 0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        chk("abort_ce_before", sram_ce, 1);
        #1 rst_n = 0;
        #1;
        chk("abort_drop", {sram_ce, busy, wbs_ack_o, la_ack}, 0);
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (wbs_ack_o || la_ack || busy) bad++;
        end
        chk("abort_no_ack", bad, 0);
        @(posedge clk); #1;
        do_txn(0, 0, 8'h04, 32'h0, 4'hF);
        chk("abort_next_lat", lat, 3);
        chk("abort_next_data", rd, 32'hDEADBEEF);

        // vector table
        for (int i = 0; i < 12; i++) begin
            do_txn(tbl[i].is_la, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].sel);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_addr", i), ads, tbl[i].wa);
            chk($sformatf("tbl%0d_be", i), bes, tbl[i].is_la ? 4'hF : tbl[i].sel);
            chk($sformatf("tbl%0d_wrong_ack", i), wrong, 0);
            if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
        end

        // random two-port traffic in the untouched window 0x40..0x4F
        reset_dut();
        for (int p = 0; p < 2; p++) begin
            act[p] = 0; gap[p] = 0; waitc[p] = 0; oth[p] = 0; exp_rd[p] = 0;
        end
        remaining = 200; cyc = 0; ce_cyc = -100; bail = 0;
        acc_addr = 0; acc_be = 0; acc_wd = 0; acc_we = 0;
        while ((remaining > 0 || act[0] || act[1]) && !bail) begin
            for (int p = 0; p < 2; p++) begin
                if (!act[p]) begin
                    if (gap[p] > 0) gap[p]--;
                    else if (remaining > 0) begin
                        remaining--;
                        act[p] = 1; waitc[p] = 0; oth[p] = 0;
                        rwe[p] = 1'($urandom % 2);
                        radr[p] = 8'h40 | 8'($urandom % 16);
                        rwd[p] = $urandom;
                        rbe[p] = (p == 0) ? 4'($urandom % 16) : 4'hF;
                    end
                end
            end
            wbs_cyc_i = act[0]; wbs_stb_i = act[0]; wbs_we_i = rwe[0];
            wbs_sel_i = rbe[0]; wbs_dat_i = rwd[0];
            wbs_adr_i = BASE | {22'd0, radr[0], 2'b00};
            la_req = act[1]; la_we = rwe[1]; la_addr = radr[1]; la_wdata = rwd[1];

            @(negedge clk);
            cyc++;
            if (sram_ce) begin
                ce_cyc = cyc; acc_addr = sram_addr; acc_be = sram_be;
                acc_wd = sram_wdata; acc_we = sram_we;
            end
            if (wbs_ack_o && la_ack) chk("rand_both_ack", 1, 0);
            for (int p = 0; p < 2; p++) begin
                ackp = (p == 0) ? wbs_ack_o : la_ack;
                if (ackp && !act[p]) chk($sformatf("rand_spurious_ack%0d", p), 1, 0);
                else if (ackp) begin
                    chk("rand_lat", cyc - ce_cyc, rwe[p] ? 1 : 2);
                    chk("rand_access", {acc_we, acc_be, acc_addr}, {rwe[p], rbe[p], radr[p]});
                    if (rwe[p]) begin
                        chk("rand_wdata", acc_wd, rwd[p]);
                        ref_mem[radr[p]] = merge(ref_mem[radr[p]], rwd[p], rbe[p]);
                    end else begin
                        exp_rd[p] = ref_mem[radr[p]];
                    end
                    chk("rand_wb_rdata", wbs_dat_o, exp_rd[0]);
                    chk("rand_la_rdata", la_rdata, exp_rd[1]);
                    chk("rand_fair", oth[p] > 1, 0);
                    if (act[1-p]) oth[1-p]++;
                    act[p] = 0;
                    gap[p] = 1 + $urandom_range(0, 2);
                    ce_cyc = -100;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (act[p]) begin
                    waitc[p]++;
                    if (waitc[p] > 40) begin
                        chk($sformatf("rand_timeout%0d", p), waitc[p], 40);
                        bail = 1;
                    end
                end
            end
            @(posedge clk); #1;
        end
        drive_idle();
        repeat (4) @(posedge clk);

        chk("never_two_ce", ce_viol, 0);
        chk("sram_zero_outside_issue", zero_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
